systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Transmit side of the systolic array operand interface: latches two square operand matrices A and B and drives the diagonally skewed left/up operand streams, plus the start pulse the array expects.
- Waits for the array's finish indication, then reports completion to the control unit.
- Sits between the scratchpad/control path and the systolic array.

Parameters:
- DATA_WIDTH, 16, width of one matrix element in bits.
- BUS_WIDTH, 64, bus width in bits. localparam MAX_DIM = BUS_WIDTH/DATA_WIDTH (D); legal D values are 1, 2, 4.
- CNT_W, 4, width of the feed cycle counter; must satisfy 2^CNT_W > 2*D.

Ports:
- clk_i  in  1  clock; reset rst_ni, asynchronous, active-low; clock clk_i.
- rst_ni  in  1  asynchronous active-low reset.
- go_i  in  1  request from control; sampled only in IDLE.
- a_mat_i  in  D*D*DATA_WIDTH  matrix A, row-major; element (r,c) at [(r*D+c+1)*DATA_WIDTH-1 -: DATA_WIDTH].
- b_mat_i  in  D*D*DATA_WIDTH  matrix B, same packing.
- sa_finish_i  in  1  finish indication from the systolic array.
- sa_start_o  out  1  start pulse to the array.
- left_o  out  D*DATA_WIDTH  skewed A stream; lane r at [(r+1)*DATA_WIDTH-1 -: DATA_WIDTH].
- up_o  out  D*DATA_WIDTH  skewed B stream; lane c at [(c+1)*DATA_WIDTH-1 -: DATA_WIDTH].
- busy_o  out  1  high from go acceptance until done_o.
- done_o  out  1  one-cycle completion pulse to control.

Behaviour:
- All outputs are registered. Reset value of every output and of the internal A/B registers is 0; the FSM resets to IDLE.
- FSM states: IDLE -> START -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE:
  - go_i=1: latch a_mat_i and b_mat_i into internal registers, go to START.
  - go_i=0: stay in IDLE.
- START (1 cycle): sa_start_o=1, left_o=up_o=0, busy_o=1, feed counter t cleared to 0. Next state FEED.
- FEED: lasts exactly 2D-1 cycles, t=0..2D-2.
  - left lane r = A[r][t-r] if 0 <= t-r < D, else 0.
  - up lane c = B[t-c][c] if 0 <= t-c < D, else 0.
  - At t=2D-2, go to DRAIN.
- DRAIN: left_o=up_o=0. Leave DRAIN only on sa_finish_i=1, which moves the FSM to DONE.
- DONE (1 cycle): done_o=1, busy_o=0. Next state IDLE.
- sa_finish_i is ignored outside DRAIN; a premature finish in START or FEED has no effect.
- go_i is ignored outside IDLE, including while in DONE. No queuing; control must re-issue go_i.
- Latched matrices are held until the next accepted go_i. Input changes during an operation have no effect.
- Latency from go_i to the first data cycle = 2 clocks: latch edge, then START.
- sa_start_o is high for exactly one cycle per accepted go_i.
- D=1: FEED lasts 1 cycle, with left=A[0][0] and up=B[0][0].
- Reset asserted mid-operation: immediate return to IDLE, all outputs 0, no done_o.
- Arithmetic: none. The block does pure selection with zero padding and no sign handling.

Optional Feature:
- Macro FEEDER_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT (default 64) and output port err_o (1 bit, reset 0).
  - A watchdog counts cycles spent in DRAIN. If it reaches TIMEOUT with no sa_finish_i, the FSM goes to DONE, pulses done_o, and sets err_o=1.
  - err_o stays set until the next accepted go_i clears it.
- When undefined: no err_o port, and DRAIN waits indefinitely.

Decomposition:
- Shared package (feeder_pkg) holds:
  - FSM state enum: IDLE, START, FEED, DRAIN, DONE.
  - MAX_DIM derivation and element/lane slice helpers.
  - Default TIMEOUT.
- One natural sub-module: skew_lane_sel. It is combinational per lane: given lane index, t and one latched row/column, it outputs the element or 0.
  - Instantiate it 2*D times through a generate loop; the registered output stage stays in systolic_feeder.

Test Plan:
- D=4, A(r,c)=4r+c+1, B=identity, go_i pulse -> sa_start_o high on cycle 1. On FEED t=0 left=(1,0,0,0) and up=(1,0,0,0). On t=3 left lanes 0..3 = (4,7,10,13), up lanes = (0,0,0,0)+B diagonals as specified. On t=6 left=(0,0,0,16). Exactly 7 FEED cycles.
- sa_finish_i asserted during FEED t=2 -> ignored; FSM still completes FEED, then waits in DRAIN. Later sa_finish_i -> done_o pulses exactly 1 cycle, busy_o falls with it.
- go_i held high throughout an operation and a_mat_i changed mid-FEED -> streams reflect the originally latched values. After DONE, control must re-issue go_i; one cycle of go_i in IDLE starts a new operation using the new a_mat_i.
- rst_ni pulled low at FEED t=3 -> all outputs 0 asynchronously, no done_o, FSM in IDLE. A subsequent go_i runs a full clean sequence.
- With FEEDER_TIMEOUT_EN, TIMEOUT=8, sa_finish_i never asserted -> done_o pulse after 8 DRAIN cycles, err_o=1. The next go_i clears err_o to 0.

Source files
------------

// File: rtl/feeder_pkg.sv
// Shared types and helpers for the systolic operand feeder.
// FEEDER_TIMEOUT_EN (in systolic_feeder) uses DEFAULT_TIMEOUT from here.
package feeder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        FEED,
        DRAIN,
        DONE
    } feeder_state_e;

    localparam int DEFAULT_TIMEOUT = 64;

    function automatic int max_dim(input int bus_width, input int data_width);
        return bus_width / data_width;
    endfunction

    // Bit offset of element (row, col) in a row-major packed square matrix.
    function automatic int elem_lsb(input int row, input int col, input int dim,
                                    input int data_width);
        return (row * dim + col) * data_width;
    endfunction

    function automatic int lane_lsb(input int lane, input int data_width);
        return lane * data_width;
    endfunction

endpackage

// File: rtl/skew_lane_sel.sv
// One skewed lane: picks vec[t - lane] when that index is inside the vector,
// otherwise drives zero. Purely combinational.
module skew_lane_sel #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_DIM    = 4,
    parameter int CNT_W      = 4
) (
    input  logic [CNT_W-1:0]              lane,
    input  logic [CNT_W-1:0]              t,
    input  logic [MAX_DIM*DATA_WIDTH-1:0] vec,
    output logic [DATA_WIDTH-1:0]         elem
);

    // The extra bit keeps lane + k from wrapping onto a small t.
    always_comb begin
        elem = '0;
        for (int k = 0; k < MAX_DIM; k++) begin
            if ({1'b0, t} == ({1'b0, lane} + (CNT_W + 1)'(k))) begin
                elem = vec[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Latches operand matrices A/B and drives the diagonally skewed left/up streams
// into the systolic array. Optional drain watchdog: define FEEDER_TIMEOUT_EN.
module systolic_feeder
    import feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BUS_WIDTH  = 64,
    parameter int CNT_W      = 4,
`ifdef FEEDER_TIMEOUT_EN
    parameter int TIMEOUT    = DEFAULT_TIMEOUT,
`endif
    localparam int MAX_DIM   = max_dim(BUS_WIDTH, DATA_WIDTH)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  go_i,
    input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] a_mat_i,
    input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] b_mat_i,
    input  logic                                  sa_finish_i,
    output logic                                  sa_start_o,
    output logic [MAX_DIM*DATA_WIDTH-1:0]         left_o,
    output logic [MAX_DIM*DATA_WIDTH-1:0]         up_o,
`ifdef FEEDER_TIMEOUT_EN
    output logic                                  err_o,
`endif
    output logic                                  busy_o,
    output logic                                  done_o
);

    localparam int MW = MAX_DIM * MAX_DIM * DATA_WIDTH;
    localparam int LW = MAX_DIM * DATA_WIDTH;
    localparam logic [CNT_W-1:0] LAST_T = CNT_W'(2 * MAX_DIM - 2);

    feeder_state_e    state_q, state_d;
    logic [CNT_W-1:0] t_q, t_d;
    logic [MW-1:0]    a_q, b_q;
    logic             load;
    logic             tmo_hit;
    logic [LW-1:0]    left_sel, up_sel;

`ifdef FEEDER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q;
`endif

    // Lane i: row i of A feeds left lane i, column i of B feeds up lane i.
    for (genvar i = 0; i < MAX_DIM; i++) begin : g_lane
        logic [LW-1:0] b_col;
        for (genvar k = 0; k < MAX_DIM; k++) begin : g_col
            assign b_col[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH] =
                b_q[elem_lsb(k, i, MAX_DIM, DATA_WIDTH) +: DATA_WIDTH];
        end

        skew_lane_sel #(.DATA_WIDTH(DATA_WIDTH), .MAX_DIM(MAX_DIM), .CNT_W(CNT_W)) u_left (
            .lane (CNT_W'(i)),
            .t    (t_d),
            .vec  (a_q[elem_lsb(i, 0, MAX_DIM, DATA_WIDTH) +: LW]),
            .elem (left_sel[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH])
        );

        skew_lane_sel #(.DATA_WIDTH(DATA_WIDTH), .MAX_DIM(MAX_DIM), .CNT_W(CNT_W)) u_up (
            .lane (CNT_W'(i)),
            .t    (t_d),
            .vec  (b_col),
            .elem (up_sel[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH])
        );
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        load    = 1'b0;
        tmo_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (go_i) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                t_d     = '0;
                state_d = FEED;
            end
            FEED: begin
                if (t_q == LAST_T) begin
                    state_d = DRAIN;
                end else begin
                    t_d = t_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (sa_finish_i) begin
                    state_d = DONE;
`ifdef FEEDER_TIMEOUT_EN
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    tmo_hit = 1'b1;
                    state_d = DONE;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            t_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sa_start_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            left_o     <= '0;
            up_o       <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            if (load) begin
                a_q <= a_mat_i;
                b_q <= b_mat_i;
            end
            sa_start_o <= (state_d == START);
            busy_o     <= (state_d inside {START, FEED, DRAIN});
            done_o     <= (state_d == DONE);
            left_o     <= (state_d == FEED) ? left_sel : '0;
            up_o       <= (state_d == FEED) ? up_sel : '0;
        end
    end

`ifdef FEEDER_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q  <= '0;
            err_o <= 1'b0;
        end else begin
            wd_q <= (state_q == DRAIN) ? wd_q + WD_W'(1) : '0;
            if (load) begin
                err_o <= 1'b0;
            end else if (tmo_hit) begin
                err_o <= 1'b1;
            end
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = tmo_hit;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder with a per-cycle expected-output queue.
// Also exercises the FEEDER_TIMEOUT_EN watchdog when that macro is defined.
module tb_systolic_feeder;

    localparam int DW = 16;
    localparam int BW = 64;
    localparam int CW = 4;
    localparam int D  = BW / DW;
    localparam int MW = D * D * DW;
    localparam int LW = D * DW;
    localparam int EW = 4 + 2 * LW;
`ifdef FEEDER_TIMEOUT_EN
    localparam int TMO = 8;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b1;
    logic          go_i = 1'b0;
    logic          sa_finish_i = 1'b0;
    logic [MW-1:0] a_mat_i = '0;
    logic [MW-1:0] b_mat_i = '0;
    logic          sa_start_o, busy_o, done_o, err_w;
    logic [LW-1:0] left_o, up_o;

    logic [EW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_fail = 0;
    logic          err_m = 1'b0;

    always #5 clk_i = ~clk_i;

    systolic_feeder #(
        .DATA_WIDTH (DW),
        .BUS_WIDTH  (BW),
`ifdef FEEDER_TIMEOUT_EN
        .TIMEOUT    (TMO),
`endif
        .CNT_W      (CW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .go_i        (go_i),
        .a_mat_i     (a_mat_i),
        .b_mat_i     (b_mat_i),
        .sa_finish_i (sa_finish_i),
        .sa_start_o  (sa_start_o),
        .left_o      (left_o),
        .up_o        (up_o),
`ifdef FEEDER_TIMEOUT_EN
        .err_o       (err_w),
`endif
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

`ifndef FEEDER_TIMEOUT_EN
    assign err_w = 1'b0;
`endif

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec rules: left lane r = A[r][t-r], up lane c = B[t-c][c], zero outside.
    function automatic logic [LW-1:0] left_m(input logic [MW-1:0] a, input int t);
        logic [LW-1:0] res = '0;
        for (int r = 0; r < D; r++) begin
            int k = t - r;
            if (k >= 0 && k < D) res[r*DW +: DW] = a[(r*D + k)*DW +: DW];
        end
        return res;
    endfunction

    function automatic logic [LW-1:0] up_m(input logic [MW-1:0] b, input int t);
        logic [LW-1:0] res = '0;
        for (int c = 0; c < D; c++) begin
            int k = t - c;
            if (k >= 0 && k < D) res[c*DW +: DW] = b[(k*D + c)*DW +: DW];
        end
        return res;
    endfunction

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] m;
        for (int i = 0; i < MW / 32; i++) m[i*32 +: 32] = $urandom();
        return m;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic s, input logic b, input logic d,
                        input logic [LW-1:0] l, input logic [LW-1:0] u);
        exp_q.push_back({s, b, d, err_m, l, u});
    endtask

    task automatic idle_cycle();
        go_i        = 1'b0;
        sa_finish_i = 1'($urandom_range(0, 1));
        a_mat_i     = rand_mat();
        tick();
        push(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic pin_feed(input int t);
        case (t)
            0: begin
                check("lit_left_t0", left_o, 64'h0000_0000_0000_0001);
                check("lit_up_t0", up_o, 64'h0000_0000_0000_0001);
            end
            3: begin
                check("lit_left_t3", left_o, {16'd13, 16'd10, 16'd7, 16'd4});
                check("lit_up_t3", up_o, 64'h0);
            end
            6: begin
                check("lit_left_t6", left_o, {16'd16, 48'd0});
                check("lit_up_t6", up_o, {16'd1, 48'd0});
            end
            default: ;
        endcase
    endtask

    // early_t: FEED index at which a premature finish is driven, -2 = during START, -1 = none.
    task automatic run_op(input logic [MW-1:0] a, input logic [MW-1:0] b, input int early_t,
                          input int drain_n, input bit hold_go, input bit tmo, input bit pin);
        go_i        = 1'b1;
        a_mat_i     = a;
        b_mat_i     = b;
        sa_finish_i = 1'b0;
        tick();
        err_m = 1'b0;
        push(1'b1, 1'b1, 1'b0, '0, '0);
        if (pin) check("lit_start", LW'(sa_start_o), LW'(1));
        go_i        = hold_go;
        a_mat_i     = rand_mat();
        b_mat_i     = rand_mat();
        sa_finish_i = (early_t == -2);
        tick();
        push(1'b0, 1'b1, 1'b0, left_m(a, 0), up_m(b, 0));
        for (int t = 0; t < 2*D - 1; t++) begin
            if (pin) pin_feed(t);
            sa_finish_i = (t == early_t);
            a_mat_i     = rand_mat();
            b_mat_i     = rand_mat();
            tick();
            if (t < 2*D - 2) push(1'b0, 1'b1, 1'b0, left_m(a, t + 1), up_m(b, t + 1));
            else             push(1'b0, 1'b1, 1'b0, '0, '0);
        end
        sa_finish_i = 1'b0;
        if (tmo) begin
`ifdef FEEDER_TIMEOUT_EN
            repeat (TMO - 1) begin
                tick();
                push(1'b0, 1'b1, 1'b0, '0, '0);
            end
            tick();
            err_m = 1'b1;
            push(1'b0, 1'b0, 1'b1, '0, '0);
`endif
        end else begin
            repeat (drain_n) begin
                tick();
                push(1'b0, 1'b1, 1'b0, '0, '0);
            end
            sa_finish_i = 1'b1;
            tick();
            push(1'b0, 1'b0, 1'b1, '0, '0);
        end
        if (pin) begin
            check("lit_done", LW'(done_o), LW'(1));
            check("lit_busy_at_done", LW'(busy_o), LW'(0));
        end
        tick();
        push(1'b0, 1'b0, 1'b0, '0, '0);
        go_i        = 1'b0;
        sa_finish_i = 1'b0;
    endtask

    task automatic reset_mid_feed();
        logic [MW-1:0] a = rand_mat();
        logic [MW-1:0] b = rand_mat();
        go_i    = 1'b1;
        a_mat_i = a;
        b_mat_i = b;
        tick();
        err_m = 1'b0;
        push(1'b1, 1'b1, 1'b0, '0, '0);
        go_i = 1'b0;
        tick();
        push(1'b0, 1'b1, 1'b0, left_m(a, 0), up_m(b, 0));
        for (int t = 0; t < 3; t++) begin
            tick();
            push(1'b0, 1'b1, 1'b0, left_m(a, t + 1), up_m(b, t + 1));
        end
        @(negedge clk_i);
        #1;
        rst_ni = 1'b0;
        err_m  = 1'b0;
        #1;
        check("rst_async_start", LW'(sa_start_o), LW'(0));
        check("rst_async_busy", LW'(busy_o), LW'(0));
        check("rst_async_done", LW'(done_o), LW'(0));
        check("rst_async_left", left_o, '0);
        check("rst_async_up", up_o, '0);
        tick();
        push(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk_i);
        #1;
        rst_ni = 1'b1;
        tick();
        push(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin : compare_proc
        logic [EW-1:0] e;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sa_start_o", LW'(sa_start_o), LW'(e[EW-1]));
                check("busy_o", LW'(busy_o), LW'(e[EW-2]));
                check("done_o", LW'(done_o), LW'(e[EW-3]));
                check("err_o", LW'(err_w), LW'(e[EW-4]));
                check("left_o", left_o, e[2*LW-1:LW]);
                check("up_o", up_o, e[LW-1:0]);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        logic [MW-1:0] a_lit, b_id, a3, b3, a4;
        #2;
        rst_ni = 1'b0;
        repeat (2) tick();
        check("reset_start", LW'(sa_start_o), LW'(0));
        check("reset_busy", LW'(busy_o), LW'(0));
        check("reset_done", LW'(done_o), LW'(0));
        check("reset_left", left_o, '0);
        check("reset_up", up_o, '0);
        @(negedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (2) idle_cycle();

        a_lit = '0;
        b_id  = '0;
        for (int r = 0; r < D; r++) begin
            for (int c = 0; c < D; c++) a_lit[(r*D + c)*DW +: DW] = DW'(4*r + c + 1);
            b_id[(r*D + r)*DW +: DW] = DW'(1);
        end
        run_op(a_lit, b_id, -1, 2, 1'b0, 1'b0, 1'b1);
        idle_cycle();

        run_op(rand_mat(), rand_mat(), 2, 4, 1'b0, 1'b0, 1'b0);

        a3 = rand_mat();
        b3 = rand_mat();
        run_op(a3, b3, -2, 1, 1'b1, 1'b0, 1'b0);
        a4 = rand_mat();
        run_op(a4, b3, -1, 0, 1'b0, 1'b0, 1'b0);

        reset_mid_feed();
        run_op(rand_mat(), rand_mat(), -1, 3, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            int sel = $urandom_range(0, 9);
            int early = (sel <= 6) ? sel : ((sel == 7) ? -2 : -1);
            run_op(rand_mat(), rand_mat(), early, $urandom_range(0, 5),
                   1'($urandom_range(0, 1)), 1'b0, 1'b0);
            repeat ($urandom_range(0, 3)) idle_cycle();
        end

`ifdef FEEDER_TIMEOUT_EN
        run_op(rand_mat(), rand_mat(), -1, 0, 1'b0, 1'b1, 1'b0);
        idle_cycle();
        check("lit_err_sticky", LW'(err_w), LW'(1));
        run_op(rand_mat(), rand_mat(), -1, 1, 1'b0, 1'b0, 1'b0);
        check("lit_err_cleared", LW'(err_w), LW'(0));
`endif

        repeat (3) idle_cycle();
        @(negedge clk_i);
        #1;
        check("queue_drained", LW'(exp_q.size()), LW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
